timer_status: RTL
=================

Name: timer_status

Overview:
- Downstream of the 8-bit timer counter; consumes its count value and mode controls.
- Detects overflow (count up, MAX->0) and underflow (count down, 0->MAX) transitions.
- Holds the events as sticky write-1-to-clear status bits (TSR) and drives a registered, level interrupt toward the interrupt controller.
- Sits beside the counter inside the timer core; the TSR read/write strobes come from the APB register decode.

Parameters:
- CNT_W, 8, counter width; MAX = 2**CNT_W-1.

Ports:
- pclk  input  1  system clock.
- preset_n  input  1  async active-low reset.
- cnt  input  CNT_W  current counter value.
- en  input  1  counter enable (same signal the counter sees).
- updown  input  1  direction: 0 = up, 1 = down.
- tcr_reconf  input  1  one-cycle reload/reconfigure pulse from TCR logic.
- tsr_wr  input  1  one-cycle TSR write strobe.
- tsr_wdata  input  3  write data; 1 clears the bit: [0]=OVF, [1]=UDF, [2]=CMP.
- ovf_ie  input  1  overflow interrupt enable.
- udf_ie  input  1  underflow interrupt enable.
- tsr  output  3  status {CMP,UDF,OVF}.
- irq  output  1  timer interrupt, level.

Behaviour:
- Reset and clock: preset_n asynchronous active-low, clock pclk.
- Reset values: tsr=3'b000, irq=0, last_cnt=0, hist_vld=0.
- History: every pclk edge, last_cnt<=cnt.
  - hist_vld<=en & ~tcr_reconf.
  - Comparison is therefore only trusted when the previous cycle was enabled and was not a reload.
- Overflow event (combinational): ovf_evt = hist_vld & en & ~tcr_reconf & ~updown & last_cnt==MAX & cnt==0.
- Underflow event (combinational): udf_evt = hist_vld & en & ~tcr_reconf & updown & last_cnt==0 & cnt==MAX.
- Loads never count as events. A reload to tdr, a reload to 0xFF or 0x00, and enabling or disabling en must not set flags.
- Holding at 0 or MAX (no count edge) produces no event, because last_cnt==cnt.
- Direction change does not create a false event: a down count from 0 to MAX with updown=1 is valid; 0->MAX while updown=0 is ignored.
- Flag latency: the event is visible in the cycle after the counter edge; the flag is set at the next pclk edge, 1 cycle after cnt changes.
- Flag update, per bit: flag <= set_evt | (flag & ~(tsr_wr & tsr_wdata[i])).
  - Simultaneous set and clear: set wins.
  - tsr_wr with data 0 leaves the flag unchanged.
- irq is registered: irq <= (tsr[0]&ovf_ie) | (tsr[1]&udf_ie) [| tsr[2]&cmp_ie with macro].
  - irq asserts 1 cycle after the flag.
  - irq deasserts 1 cycle after the flag is cleared or its enable drops.
- Reset mid-operation clears flags, irq and history immediately; the first cycle after reset cannot produce an event.
- Without the optional feature, tsr[2] reads 0 and tsr_wdata[2] is ignored.

Optional Feature:
- Macro: TMR_CMP_MATCH_EN.
- Defined: adds ports tcmp (input, CNT_W, compare value) and cmp_ie (input, 1).
  - cmp_evt = hist_vld & en & ~tcr_reconf & cnt!=last_cnt & cnt==tcmp.
  - cmp_evt sets tsr[2] (W1C) and contributes to irq.
  - A match only fires on a count step into the value, not while holding.
- Undefined: no tcmp or cmp_ie ports; tsr[2] is tied 0.

Decomposition:
- Package timer_pkg holds:
  - TSR bit indices TSR_OVF=0, TSR_UDF=1, TSR_CMP=2.
  - TSR_W=3.
  - Default CNT_W=8.
- Sub-module sticky_flag (inputs set, clr; output q; async reset; set priority) is instantiated once per TSR bit.

Test Plan:
- Up count: updown=0, en=1, count steps FE->FF->00 → tsr=3'b001 one cycle after 00; with ovf_ie=1, irq=1 one cycle later.
- Down count: updown=1, steps 01->00->FF → tsr[1]=1; with udf_ie=0, irq stays 0; then set udf_ie=1 → irq=1 next cycle.
- Reload: cnt=00, updown=1, tcr_reconf pulse loads FF → tsr stays 000; same for a tdr load of 00 from FF while counting up.
- Clear and collision: tsr=011, tsr_wr with wdata=001 → tsr=010, and irq follows 1 cycle later. Then an overflow in the same cycle as a W1C of OVF → tsr[0] stays 1.
- Enable and reset: en 0->1 with cnt jumping FF->00 (reconfigured while disabled) → no flag. Assert preset_n=0 while tsr=011, irq=1 → all outputs 0 immediately.
- Compare (TMR_CMP_MATCH_EN): tcmp=0x10, cmp_ie=1, count 0F->10 → tsr[2]=1, irq next cycle. Holding at 10 after a W1C → no re-set.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the timer core: TSR bit layout and default counter width.
package timer_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int TSR_W     = 3;
    localparam int TSR_OVF   = 0;
    localparam int TSR_UDF   = 1;
    localparam int TSR_CMP   = 2;

endpackage

// File: rtl/sticky_flag.sv
// One sticky status bit: set has priority over a same-cycle clear.
module sticky_flag (
    input  logic pclk,
    input  logic preset_n,
    input  logic set,
    input  logic clr,
    output logic q
);

    logic q_r;

    // Hold the flag until cleared; a new event in the clear cycle keeps it set
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            q_r <= 1'b0;
        end else begin
            q_r <= set | (q_r & ~clr);
        end
    end

    assign q = q_r;

endmodule

// File: rtl/timer_status.sv
// Overflow/underflow detection with W1C status (TSR) and a registered level irq.
// Optional compare-match flag on TSR[2] is enabled by defining TMR_CMP_MATCH_EN.
module timer_status
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    input  logic             updown,
    input  logic             tcr_reconf,
    input  logic             tsr_wr,
    input  logic [TSR_W-1:0] tsr_wdata,
    input  logic             ovf_ie,
    input  logic             udf_ie,
`ifdef TMR_CMP_MATCH_EN
    input  logic [CNT_W-1:0] tcmp,
    input  logic             cmp_ie,
`endif
    output logic [TSR_W-1:0] tsr,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] last_cnt_r;
    logic             hist_vld_r;
    logic             irq_r;

    logic             step_ok_s;
    logic             ovf_evt_s;
    logic             udf_evt_s;
    logic             cmp_evt_s;
    logic [TSR_W-1:0] set_s;
    logic [TSR_W-1:0] clr_s;
    logic [TSR_W-1:0] ie_s;

    // Previous-cycle counter sample; only trusted after an enabled, non-reload cycle
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            last_cnt_r <= {CNT_W{1'b0}};
            hist_vld_r <= 1'b0;
        end else begin
            last_cnt_r <= cnt;
            hist_vld_r <= en & ~tcr_reconf;
        end
    end

    // Event detection from a genuine count step, plus W1C decode
    always_comb begin
        step_ok_s = hist_vld_r & en & ~tcr_reconf;
        ovf_evt_s = step_ok_s & ~updown & (last_cnt_r == CNT_MAX) & (cnt == CNT_ZERO);
        udf_evt_s = step_ok_s &  updown & (last_cnt_r == CNT_ZERO) & (cnt == CNT_MAX);
`ifdef TMR_CMP_MATCH_EN
        cmp_evt_s     = step_ok_s & (cnt != last_cnt_r) & (cnt == tcmp);
        ie_s[TSR_CMP] = cmp_ie;
`else
        cmp_evt_s     = 1'b0;
        ie_s[TSR_CMP] = 1'b0;
`endif
        ie_s[TSR_OVF]  = ovf_ie;
        ie_s[TSR_UDF]  = udf_ie;
        set_s[TSR_OVF] = ovf_evt_s;
        set_s[TSR_UDF] = udf_evt_s;
        set_s[TSR_CMP] = cmp_evt_s;
        if (tsr_wr) begin
            clr_s = tsr_wdata;
        end else begin
            clr_s = {TSR_W{1'b0}};
        end
    end

    // Without the compare feature bit 2 never sees a set, so it stays 0
    for (genvar i = 0; i < TSR_W; i++) begin : g_flag
        sticky_flag u_flag (
            .pclk     (pclk),
            .preset_n (preset_n),
            .set      (set_s[i]),
            .clr      (clr_s[i]),
            .q        (tsr[i])
        );
    end

    // Level interrupt, one cycle behind the flags and their enables
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(tsr & ie_s);
        end
    end

    assign irq = irq_r;

endmodule
